// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the CPU-side memory-bus arbiter.
// Holds the FSM state encoding, region decode constants and the idle-bus values.
package nes_bus_pkg;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t StIdle   = 2'd0;
    localparam bus_state_t StAccess = 2'd1;
    localparam bus_state_t StData   = 2'd2;

    // Decoded from address bits [15:13].
    localparam logic [2:0] WRAM_HI = 3'b000;
    localparam logic [2:0] PPU_HI  = 3'b001;

    localparam logic IDLE_R_NW    = 1'b1;
    localparam logic IDLE_WRAM_EN = 1'b0;
    localparam logic IDLE_PPU_NCS = 1'b1;
    localparam logic IDLE_PRG_NCE = 1'b1;

endpackage

// File: rtl/nes_bus_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request found
// at or after ptr_i, wrapping around the request vector.
module nes_bus_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            idx = (int'(ptr_i) + off) % int'(NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nes_bus_arbiter.sv
// CPU memory-bus arbiter/decoder: IDLE -> ACCESS -> DATA transaction per grant.
// Define NES_BUS_ARB_TIMEOUT_EN to enable the lock watchdog and sticky err_out.
module nes_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 8,
    parameter int unsigned ARB_RR      = 1,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_MASTERS-1:0]    req_in,
    input  logic [NUM_MASTERS-1:0]    lock_in,
    input  logic [NUM_MASTERS-1:0]    r_nw_in,
    input  logic [NUM_MASTERS*AW-1:0] a_in,
    input  logic [NUM_MASTERS*DW-1:0] d_in,
    output logic [NUM_MASTERS-1:0]    ack_out,
    output logic [DW-1:0]             d_out,
    output logic [NUM_MASTERS-1:0]    gnt_out,
    output logic [AW-1:0]             mc_a_out,
    output logic                      mc_r_nw_out,
    output logic [DW-1:0]             mc_d_out,
    input  logic [DW-1:0]             mc_d_in,
    output logic                      wram_en_out,
    output logic                      ppu_ncs_out,
    output logic                      prg_nce_out,
    output logic                      err_out
);

    localparam int unsigned PW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || AW < 16 || TIMEOUT == 0) begin : g_param_check
        $error("nes_bus_arbiter: parameter out of range");
    end

    bus_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic [NUM_MASTERS-1:0] cand, win, fixed_gnt;
    logic [NUM_MASTERS-2:0] rr_gnt_hi;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [DW-1:0]          dout_q, dout_d;
    logic                   bus_active, keep, grant_new, lock_expired;
    int                     owner_idx, win_idx;

    // The owner's request is stale once it reaches DATA, so it never re-wins on its own.
    assign cand = (state_q == StData) ? (req_in & ~gnt_q) : req_in;

    nes_bus_rr_pick #(
        .NUM_REQ(NUM_MASTERS - 1),
        .PTR_W  (PW)
    ) u_rr_pick (
        .req_i(cand[NUM_MASTERS-1:1]),
        .ptr_i(ptr_q - PW'(1)),
        .gnt_o(rr_gnt_hi)
    );

    always_comb begin
        fixed_gnt = '0;
        for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                fixed_gnt    = '0;
                fixed_gnt[i] = 1'b1;
            end
        end
        win = (ARB_RR != 0 && !cand[0]) ? {rr_gnt_hi, 1'b0} : fixed_gnt;
        win_idx   = 0;
        owner_idx = 0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (win[i])   win_idx   = i;
            if (gnt_q[i]) owner_idx = i;
        end
    end

    assign bus_active  = (state_q == StAccess) && |(gnt_q & req_in);
    assign mc_a_out    = bus_active ? a_in[owner_idx*AW +: AW] : '0;
    assign mc_r_nw_out = bus_active ? r_nw_in[owner_idx] : IDLE_R_NW;
    assign mc_d_out    = bus_active ? d_in[owner_idx*DW +: DW] : '0;
    assign wram_en_out = bus_active ? (mc_a_out[15:13] == WRAM_HI) : IDLE_WRAM_EN;
    assign ppu_ncs_out = bus_active ? (mc_a_out[15:13] != PPU_HI) : IDLE_PPU_NCS;
    assign prg_nce_out = bus_active ? !mc_a_out[15] : IDLE_PRG_NCE;

    assign keep = |(gnt_q & lock_in & req_in) && !lock_expired;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        dout_d    = dout_q;
        grant_new = 1'b0;
        unique case (state_q)
            StIdle: grant_new = |cand;
            StAccess: begin
                state_d = StData;
                ack_d   = gnt_q;
                if (bus_active && mc_r_nw_out) dout_d = mc_d_in;
            end
            StData: begin
                if (keep) begin
                    state_d = StAccess;
                end else if (|cand) begin
                    grant_new = 1'b1;
                end else begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant_new) begin
            state_d = StAccess;
            gnt_d   = win;
            if (!win[0]) begin
                ptr_d = (win_idx == int'(NUM_MASTERS) - 1) ? PW'(1) : PW'(win_idx + 1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ack_q   <= '0;
            dout_q  <= '0;
            ptr_q   <= PW'(1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_out = gnt_q;
    assign ack_out = ack_q;
    assign d_out   = dout_q;

`ifdef NES_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, hold;

    assign hold         = (state_q != StIdle) && |(gnt_q & lock_in) && |(req_in & ~gnt_q);
    assign lock_expired = (cnt_q >= CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (grant_new || state_q == StIdle) begin
            cnt_d = '0;
        end else if (hold && !lock_expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | lock_expired;
        end
    end

    assign err_out = err_q;
`else
    assign lock_expired = 1'b0;
    assign err_out      = 1'b0;
`endif

endmodule

// File: tb/tb_nes_bus_arbiter.sv
// Directed bench for nes_bus_arbiter: single-transaction table plus priority,
// round-robin, reset-in-ACCESS and lock sequences.
module tb_nes_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, r_nw;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    ack, gnt;
    logic [DW-1:0]   dout, mc_d, mc_din;
    logic [AW-1:0]   mc_a;
    logic            mc_r_nw, wram_en, ppu_ncs, prg_nce, err;

    always #5 clk = ~clk;

    nes_bus_arbiter #(
        .NUM_MASTERS(N),
        .AW         (AW),
        .DW         (DW),
        .ARB_RR     (1),
        .TIMEOUT    (16)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .req_in     (req),
        .lock_in    (lock),
        .r_nw_in    (r_nw),
        .a_in       (a),
        .d_in       (d),
        .ack_out    (ack),
        .d_out      (dout),
        .gnt_out    (gnt),
        .mc_a_out   (mc_a),
        .mc_r_nw_out(mc_r_nw),
        .mc_d_out   (mc_d),
        .mc_d_in    (mc_din),
        .wram_en_out(wram_en),
        .ppu_ncs_out(ppu_ncs),
        .prg_nce_out(prg_nce),
        .err_out    (err)
    );

    typedef struct {
        int          m;
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  sd;
        logic        wram;
        logic        ppu_ncs;
        logic        prg_nce;
        logic [7:0]  dout;
    } vec_t;

    vec_t         vecs [8];
    vec_t         v;
    logic [N-1:0] oh;
    int           checks = 0;
    int           errors = 0;
    int           hold, acks2;
    logic         got1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_mc_a"}, 32'(mc_a), 32'h0);
        check({tag, "_mc_r_nw"}, 32'(mc_r_nw), 32'h1);
        check({tag, "_mc_d"}, 32'(mc_d), 32'h0);
        check({tag, "_wram_en"}, 32'(wram_en), 32'h0);
        check({tag, "_ppu_ncs"}, 32'(ppu_ncs), 32'h1);
        check({tag, "_prg_nce"}, 32'(prg_nce), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 1'b1, 16'h0123, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
        vecs[1] = '{1, 1'b0, 16'h2000, 8'h80, 8'h99, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{2, 1'b1, 16'h8000, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3};
        vecs[3] = '{0, 1'b1, 16'h1FFF, 8'h00, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[4] = '{2, 1'b0, 16'h3FFF, 8'h7E, 8'h66, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[5] = '{1, 1'b1, 16'h4020, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[6] = '{0, 1'b1, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1, 1'b1, 16'hE000, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};

        rst = 1'b1; req = '0; lock = '0; r_nw = '1; a = '0; d = '0; mc_din = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check_idle_bus("rst");
        rst = 1'b0;

        // Single transactions from the table.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            @(negedge clk);
            a = {N{16'hBEEF}};
            d = {N{8'hEE}};
            r_nw = '1;
            a[v.m*AW +: AW] = v.addr;
            d[v.m*DW +: DW] = v.wd;
            r_nw[v.m] = v.rnw;
            mc_din = v.sd;
            oh = '0;
            oh[v.m] = 1'b1;
            req = oh;
            @(negedge clk);
            check("vec_gnt", 32'(gnt), 32'(oh));
            check("vec_ack_access", 32'(ack), 32'h0);
            check("vec_mc_a", 32'(mc_a), 32'(v.addr));
            check("vec_mc_r_nw", 32'(mc_r_nw), 32'(v.rnw));
            check("vec_mc_d", 32'(mc_d), 32'(v.wd));
            check("vec_wram_en", 32'(wram_en), 32'(v.wram));
            check("vec_ppu_ncs", 32'(ppu_ncs), 32'(v.ppu_ncs));
            check("vec_prg_nce", 32'(prg_nce), 32'(v.prg_nce));
            @(negedge clk);
            check("vec_ack", 32'(ack), 32'(oh));
            check("vec_dout", 32'(dout), 32'(v.dout));
            check("vec_r_nw_data", 32'(mc_r_nw), 32'h1);
            req = '0;
            mc_din = '0;
            @(negedge clk);
            check("vec_gnt_idle", 32'(gnt), 32'h0);
            check("vec_ack_idle", 32'(ack), 32'h0);
        end

        // Masters 0 and 2 together: 0 first, 2 two cycles later.
        r_nw = '1;
        a = {16'h8000, 16'h0000, 16'h8000};
        req = 3'b101;
        @(negedge clk);
        check("prio_gnt0", 32'(gnt), 32'h1);
        check("prio_prg0", 32'(prg_nce), 32'h0);
        @(negedge clk);
        check("prio_ack0", 32'(ack), 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        check("prio_gnt2", 32'(gnt), 32'h4);
        check("prio_prg2", 32'(prg_nce), 32'h0);
        check("prio_ack_gap", 32'(ack), 32'h0);
        @(negedge clk);
        check("prio_ack2", 32'(ack), 32'h4);
        req = '0;
        @(negedge clk);

        // Reset while a write is in ACCESS.
        a = {16'h0000, 16'h0000, 16'h0000};
        d = {8'h00, 8'h55, 8'h00};
        r_nw = 3'b101;
        req = 3'b010;
        @(negedge clk);
        check("rsta_gnt", 32'(gnt), 32'h2);
        check("rsta_write", 32'(mc_r_nw), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rsta_gnt_rst", 32'(gnt), 32'h0);
        check("rsta_ack_rst", 32'(ack), 32'h0);
        check("rsta_dout_rst", 32'(dout), 32'h0);
        check_idle_bus("rsta");
        rst = 1'b0;
        req = '0;
        r_nw = '1;
        @(negedge clk);
        check("rsta_no_ack", 32'(ack), 32'h0);
        check("rsta_no_strobe", 32'(mc_r_nw), 32'h1);

        // Round-robin between 1 and 2; the last access loses its request mid-flight.
        a = {16'h8000, 16'h0000, 16'h0000};
        req = 3'b110;
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 3'b010 : 3'b100;
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(oh));
            check("rr_ack_access", 32'(ack), 32'h0);
            if (k == 3) begin
                req = '0;
                #1;
                check("drop_prg_nce", 32'(prg_nce), 32'h1);
                check("drop_mc_a", 32'(mc_a), 32'h0);
            end
            @(negedge clk);
            check("rr_ack", 32'(ack), 32'(oh));
        end
        @(negedge clk);
        check("rr_gnt_idle", 32'(gnt), 32'h0);
        check("rr_ack_idle", 32'(ack), 32'h0);

        // Master 2 locks while master 1 waits.
        a = {16'h6000, 16'h0100, 16'h0000};
        req = 3'b100;
        lock = 3'b100;
        for (int c = 0; c < 10 && gnt != 3'b100; c++) @(negedge clk);
        check("lock_grant", 32'(gnt), 32'h4);
        check("lock_err_before", 32'(err), 32'h0);
        req[1] = 1'b1;
        got1 = 1'b0;
        hold = 0;
        acks2 = 0;
        for (int c = 0; c < 60 && !got1; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                got1 = 1'b1;
            end else begin
                if (gnt == 3'b100) hold++;
                if (ack[2]) begin
                    acks2++;
`ifndef NES_BUS_ARB_TIMEOUT_EN
                    if (acks2 == 4) begin
                        lock[2] = 1'b0;
                        req[2] = 1'b0;
                    end
`endif
                end
            end
        end
        check("lock_m1_acked", 32'(got1), 32'h1);
`ifdef NES_BUS_ARB_TIMEOUT_EN
        check("lock_hold_range", 32'(hold >= 16 && hold <= 18), 32'h1);
        check("lock_m2_acks", 32'(acks2 >= 8), 32'h1);
        check("lock_err_set", 32'(err), 32'h1);
`else
        check("lock_hold", 32'(hold), 32'd7);
        check("lock_m2_acks", 32'(acks2), 32'd4);
        check("lock_err_tied", 32'(err), 32'h0);
`endif
        req = '0;
        lock = '0;
        repeat (4) @(negedge clk);
        check("lock_gnt_idle", 32'(gnt), 32'h0);
`ifdef NES_BUS_ARB_TIMEOUT_EN
        check("lock_err_sticky", 32'(err), 32'h1);
`else
        check("lock_err_idle", 32'(err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
